// File: rtl/vga_bounce_box_pkg.sv
// Shared definitions for the bouncing-square pixel source: colours, VGA window timing,
// the axis direction type and the colour-cycle helper.
package vga_bounce_box_pkg;

    // {R,G,B} colour codes as seen by the controller's iVGA_RGB input.
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    // Counter offsets of the first visible pixel/line and the visible extent.
    localparam int HS_OFFSET = 48;
    localparam int HS_ACTIVE = 640;
    localparam int VS_OFFSET = 29;
    localparam int VS_ACTIVE = 480;

    localparam int H_START_DEF = HS_OFFSET;
    localparam int H_END_DEF   = HS_OFFSET + HS_ACTIVE;
    localparam int V_START_DEF = VS_OFFSET;
    localparam int V_END_DEF   = VS_OFFSET + VS_ACTIVE;

    localparam int BOX_SIZE_DEF = 32;
    localparam int STEP_DEF     = 2;

    typedef enum logic {
        DIR_FWD = 1'b0,   // right / down
        DIR_REV = 1'b1    // left / up
    } dir_e;

    // Colour-cycle successor; black is skipped so the square never vanishes.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == WHITE) ? BLUE : c + 3'b001;
    endfunction

endpackage

// File: rtl/vga_box_axis.sv
// One motion axis of the bouncing square: position and direction registers that step
// once per update strobe and bounce/clamp at the window edges.
module vga_box_axis
    import vga_bounce_box_pkg::*;
#(
    parameter int START = H_START_DEF,
    parameter int END   = H_END_DEF,
    parameter int SIZE  = BOX_SIZE_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       update_i,
    output logic [9:0] pos_o,
    output logic       dir_o,
    output logic       bounce_o
);

    // 11-bit working width: position + SIZE + STEP cannot wrap.
    localparam logic [10:0] START_W = 11'(START);
    localparam logic [10:0] END_W   = 11'(END);
    localparam logic [10:0] SIZE_W  = 11'(SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] MAX_W   = 11'(END - SIZE);

    logic [9:0] pos_q, pos_d;
    dir_e       dir_q, dir_d;
    logic       bounce;
    logic [10:0] pos_w;

    assign pos_w = {1'b0, pos_q};

    // NOTE: every next-state signal is given its hold value first, so no branch can infer a latch.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        bounce = 1'b0;
        if (update_i) begin
            if (dir_q == DIR_FWD) begin
                if (pos_w + SIZE_W + STEP_W >= END_W) begin
                    pos_d  = MAX_W[9:0];
                    dir_d  = DIR_REV;
                    bounce = 1'b1;
                end else begin
                    pos_d = pos_q + STEP_W[9:0];
                end
            end else begin
                if (pos_w < START_W + STEP_W) begin
                    pos_d  = START_W[9:0];
                    dir_d  = DIR_FWD;
                    bounce = 1'b1;
                end else begin
                    pos_d = pos_q - STEP_W[9:0];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; the reset branch is synchronous.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pos_q <= START_W[9:0];
            dir_q <= DIR_FWD;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o    = pos_q;
    assign dir_o    = (dir_q == DIR_REV);
    assign bounce_o = bounce;

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing-square pixel source for the VGA controller. Optional macro
// BOUNCE_COLOR_CYCLE_EN makes the square change colour on every bounce.
module vga_bounce_box
    import vga_bounce_box_pkg::*;
#(
    parameter int         H_START   = H_START_DEF,
    parameter int         H_END     = H_END_DEF,
    parameter int         V_START   = V_START_DEF,
    parameter int         V_END     = V_END_DEF,
    parameter int         BOX_SIZE  = BOX_SIZE_DEF,
    parameter int         STEP      = STEP_DEF,
    parameter logic [2:0] BOX_COLOR = BLUE,
    parameter logic [2:0] BG_COLOR  = BLACK
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] iHcounter,
    input  logic [9:0] iVcounter,
    input  logic       iEnable,
    output logic [2:0] oVGA_RGB,
    output logic       oFrameTick,
    output logic [9:0] oBoxX,
    output logic [9:0] oBoxY
);

    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);

    logic       tick_q, tick_d;
    logic       update;
    logic [9:0] box_x, box_y;
    logic       x_dir, y_dir;
    logic       x_bounce, y_bounce;
    logic [2:0] box_color;
    logic       in_x, in_y;
    logic [2:0] rgb_q, rgb_d;

    // End-of-frame marker: first pixel of the line just past the active window.
    assign tick_d = (iVcounter == 10'(V_END)) && (iHcounter == 10'd0);
    assign update = tick_q && iEnable;

    vga_box_axis #(
        .START (H_START),
        .END   (H_END),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_x (
        .Clock    (Clock),
        .Reset    (Reset),
        .update_i (update),
        .pos_o    (box_x),
        .dir_o    (x_dir),
        .bounce_o (x_bounce)
    );

    vga_box_axis #(
        .START (V_START),
        .END   (V_END),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_y (
        .Clock    (Clock),
        .Reset    (Reset),
        .update_i (update),
        .pos_o    (box_y),
        .dir_o    (y_dir),
        .bounce_o (y_bounce)
    );

`ifdef BOUNCE_COLOR_CYCLE_EN
    logic [2:0] color_q, color_d;

    // A corner bounce is a single event, hence the OR.
    assign color_d = (x_bounce || y_bounce) ? next_color(color_q) : color_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            color_q <= BOX_COLOR;
        end else begin
            color_q <= color_d;
        end
    end

    assign box_color = color_q;

    logic unused_axis;
    assign unused_axis = x_dir ^ y_dir;
`else
    assign box_color = BOX_COLOR;

    logic unused_axis;
    assign unused_axis = x_dir ^ y_dir ^ x_bounce ^ y_bounce;
`endif

    // Position only moves at the tick, so the square is stable across a whole frame.
    assign in_x = ({1'b0, iHcounter} >= {1'b0, box_x}) &&
                  ({1'b0, iHcounter} <  {1'b0, box_x} + SIZE_W);
    assign in_y = ({1'b0, iVcounter} >= {1'b0, box_y}) &&
                  ({1'b0, iVcounter} <  {1'b0, box_y} + SIZE_W);

    assign rgb_d = (in_x && in_y) ? box_color : BG_COLOR;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tick_q <= 1'b0;
            rgb_q  <= BLACK;
        end else begin
            tick_q <= tick_d;
            rgb_q  <= rgb_d;
        end
    end

    assign oVGA_RGB   = rgb_q;
    assign oFrameTick = tick_q;
    assign oBoxX      = box_x;
    assign oBoxY      = box_y;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Self-checking bench for vga_bounce_box: pixel/tick vector table plus directed
// sequences for motion, bounces, freeze, mid-frame reset and a natural corner bounce.
module tb_vga_bounce_box;

    localparam int H_START = 48;
    localparam int H_END   = 688;
    localparam int V_START = 29;
    localparam int V_END   = 509;
    localparam int BOX     = 32;
    localparam int STP     = 2;
    localparam logic [2:0] C_BOX = 3'b001;
    localparam logic [2:0] C_BG  = 3'b000;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [9:0] iHcounter;
    logic [9:0] iVcounter;
    logic       iEnable;
    logic [2:0] oVGA_RGB;
    logic       oFrameTick;
    logic [9:0] oBoxX;
    logic [9:0] oBoxY;

    vga_bounce_box dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iHcounter  (iHcounter),
        .iVcounter  (iVcounter),
        .iEnable    (iEnable),
        .oVGA_RGB   (oVGA_RGB),
        .oFrameTick (oFrameTick),
        .oBoxX      (oBoxX),
        .oBoxY      (oBoxY)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         mx, my;
    bit         mdx, mdy;
    logic [2:0] mcol;
    bit         m_bx, m_by;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       en;
        logic [2:0] rgb;
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic en);
        iHcounter = 10'(h);
        iVcounter = 10'(v);
        iEnable   = en;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic axis_step(input int p, input bit neg, input int s, input int e,
                             output int np, output bit nneg, output bit b);
        np   = p;
        nneg = neg;
        b    = 1'b0;
        if (!neg) begin
            if (p + BOX + STP >= e) begin
                np = e - BOX; nneg = 1'b1; b = 1'b1;
            end else begin
                np = p + STP;
            end
        end else begin
            if (p < s + STP) begin
                np = s; nneg = 1'b0; b = 1'b1;
            end else begin
                np = p - STP;
            end
        end
    endtask

    task automatic model_reset();
        mx = H_START; my = V_START; mdx = 1'b0; mdy = 1'b0; mcol = C_BOX;
    endtask

    task automatic model_update();
        int nx, ny;
        bit ndx, ndy;
        axis_step(mx, mdx, H_START, H_END, nx, ndx, m_bx);
        axis_step(my, mdy, V_START, V_END, ny, ndy, m_by);
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
`ifdef BOUNCE_COLOR_CYCLE_EN
        if (m_bx || m_by) mcol = (mcol == 3'b111) ? 3'b001 : mcol + 3'b001;
`endif
    endtask

    // One frame boundary: tick cycle then the update cycle; ok clears on any deviation.
    task automatic run_frame(input logic en, output bit ok);
        ok = 1'b1;
        drive(0, V_END, en);
        step();
        if (oFrameTick !== 1'b1 || oBoxX !== 10'(mx) || oBoxY !== 10'(my)) ok = 1'b0;
        drive(1, V_END, en);
        step();
        if (en) model_update();
        if (oFrameTick !== 1'b0 || oBoxX !== 10'(mx) || oBoxY !== 10'(my)) ok = 1'b0;
    endtask

    task automatic pixel(input string name, input int h, input int v, input logic [2:0] exp);
        drive(h, v, 1'b0);
        step();
        check(name, 32'(oVGA_RGB), 32'(exp));
    endtask

    initial begin
        int  pulses;
        int  bad;
        int  max_x, min_x, max_y, min_y;
        int  x304, x305, y224, y225;
        bit  ok;

        vecs[0] = '{10'd48,  10'd29,  1'b0, C_BOX, 1'b0, 10'd48, 10'd29};
        vecs[1] = '{10'd79,  10'd60,  1'b0, C_BOX, 1'b0, 10'd48, 10'd29};
        vecs[2] = '{10'd80,  10'd29,  1'b0, C_BG,  1'b0, 10'd48, 10'd29};
        vecs[3] = '{10'd47,  10'd29,  1'b0, C_BG,  1'b0, 10'd48, 10'd29};
        vecs[4] = '{10'd48,  10'd61,  1'b0, C_BG,  1'b0, 10'd48, 10'd29};
        vecs[5] = '{10'd79,  10'd28,  1'b0, C_BG,  1'b0, 10'd48, 10'd29};
        vecs[6] = '{10'd0,   10'd509, 1'b0, C_BG,  1'b1, 10'd48, 10'd29};
        vecs[7] = '{10'd48,  10'd29,  1'b0, C_BOX, 1'b0, 10'd48, 10'd29};
        vecs[8] = '{10'd0,   10'd508, 1'b0, C_BG,  1'b0, 10'd48, 10'd29};
        vecs[9] = '{10'd1,   10'd509, 1'b0, C_BG,  1'b0, 10'd48, 10'd29};

        // Reset and release
        Reset = 1'b1;
        drive(0, 0, 1'b0);
        step();
        step();
        check("reset_x",    32'(oBoxX),      32'(H_START));
        check("reset_y",    32'(oBoxY),      32'(V_START));
        check("reset_rgb",  32'(oVGA_RGB),   32'(0));
        check("reset_tick", 32'(oFrameTick), 32'(0));
        Reset = 1'b0;
        step();
        check("release_x",    32'(oBoxX),      32'(H_START));
        check("release_y",    32'(oBoxY),      32'(V_START));
        check("release_rgb",  32'(oVGA_RGB),   32'(0));
        check("release_tick", 32'(oFrameTick), 32'(0));

        // Pixel / tick vector table with the square parked at reset position
        for (int i = 0; i < 10; i++) begin
            drive(int'(vecs[i].h), int'(vecs[i].v), vecs[i].en);
            step();
            check($sformatf("vec%0d_rgb", i),  32'(oVGA_RGB),   32'(vecs[i].rgb));
            check($sformatf("vec%0d_tick", i), 32'(oFrameTick), 32'(vecs[i].tick));
            check($sformatf("vec%0d_x", i),    32'(oBoxX),      32'(vecs[i].x));
            check($sformatf("vec%0d_y", i),    32'(oBoxY),      32'(vecs[i].y));
        end

        // First motion step
        model_reset();
        drive(0, V_END, 1'b1);
        step();
        check("move_tick",    32'(oFrameTick), 32'(1));
        check("move_x_held",  32'(oBoxX),      32'(48));
        drive(1, V_END, 1'b1);
        step();
        model_update();
        check("move_tick_off", 32'(oFrameTick), 32'(0));
        check("move_x",        32'(oBoxX),      32'(50));
        check("move_y",        32'(oBoxY),      32'(31));

        pixel("moved_left_out", 49, 31, C_BG);
        pixel("moved_corner_in", 50, 31, C_BOX);
        pixel("moved_top_out",  50, 30, C_BG);
        pixel("moved_far_in",   81, 62, C_BOX);
        pixel("moved_far_out",  82, 62, C_BG);

        // Frozen across three ticks
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            drive(0, V_END, 1'b0);
            step();
            if (oFrameTick === 1'b1) pulses++;
            drive(1, V_END, 1'b0);
            step();
            if (oFrameTick === 1'b1) pulses++;
        end
        check("freeze_pulses", 32'(pulses), 32'(3));
        check("freeze_x",      32'(oBoxX),  32'(50));
        check("freeze_y",      32'(oBoxY),  32'(31));

        // Mid-frame reset, tick suppressed while in reset, then resumes
        drive(60, 100, 1'b1);
        step();
        Reset = 1'b1;
        drive(50, 31, 1'b0);
        step();
        check("midrst_x",    32'(oBoxX),      32'(H_START));
        check("midrst_y",    32'(oBoxY),      32'(V_START));
        check("midrst_rgb",  32'(oVGA_RGB),   32'(0));
        check("midrst_tick", 32'(oFrameTick), 32'(0));
        drive(0, V_END, 1'b0);
        step();
        check("rst_tick_blocked", 32'(oFrameTick), 32'(0));
        Reset = 1'b0;
        step();
        check("tick_resumes", 32'(oFrameTick), 32'(1));
        drive(1, V_END, 1'b0);
        step();
        check("post_rst_x", 32'(oBoxX), 32'(H_START));

        // 600 frames from reset: first X and Y bounces
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model_reset();
        bad = 0;
        max_x = H_START; min_x = H_START; max_y = V_START; min_y = V_START;
        x304 = 0; x305 = 0; y224 = 0; y225 = 0;
        for (int k = 1; k <= 600; k++) begin
            run_frame(1'b1, ok);
            if (!ok) bad++;
            if (int'(oBoxX) > max_x) max_x = int'(oBoxX);
            if (int'(oBoxX) < min_x) min_x = int'(oBoxX);
            if (int'(oBoxY) > max_y) max_y = int'(oBoxY);
            if (int'(oBoxY) < min_y) min_y = int'(oBoxY);
            if (k == 304) x304 = int'(oBoxX);
            if (k == 305) x305 = int'(oBoxX);
            if (k == 224) y224 = int'(oBoxY);
            if (k == 225) y225 = int'(oBoxY);
        end
        check("run600_frames_bad", 32'(bad),   32'(0));
        check("x_at_bounce",       32'(x304),  32'(656));
        check("x_after_bounce",    32'(x305),  32'(654));
        check("y_at_bounce",       32'(y224),  32'(477));
        check("y_after_bounce",    32'(y225),  32'(475));
        check("x_max",             32'(max_x), 32'(656));
        check("x_min_ok",          32'(min_x >= H_START), 32'(1));
        check("y_max",             32'(max_y), 32'(477));
        check("y_min_ok",          32'(min_y >= V_START), 32'(1));

        // Continue to update 26491, where X hits the right edge while Y hits the top
        bad = 0;
        for (int k = 601; k <= 26490; k++) begin
            run_frame(1'b1, ok);
            if (!ok) bad++;
            if (int'(oBoxX) > H_END - BOX || int'(oBoxX) < H_START) bad++;
            if (int'(oBoxY) > V_END - BOX || int'(oBoxY) < V_START) bad++;
        end
        check("long_run_bad",   32'(bad),   32'(0));
        check("pre_corner_x",   32'(oBoxX), 32'(654));
        check("pre_corner_y",   32'(oBoxY), 32'(29));
        pixel("pre_corner_color", 654, 29, mcol);

        run_frame(1'b1, ok);
        check("corner_frame_ok", 32'(ok),    32'(1));
        check("corner_x",        32'(oBoxX), 32'(656));
        check("corner_y",        32'(oBoxY), 32'(29));
        pixel("corner_color", 656, 29, mcol);
        run_frame(1'b1, ok);
        check("after_corner_ok", 32'(ok),    32'(1));
        check("after_corner_x",  32'(oBoxX), 32'(654));
        check("after_corner_y",  32'(oBoxY), 32'(31));
        pixel("after_corner_color", 654, 31, mcol);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
